// File: rtl/uart_alu_ctrl_if.sv
// Byte-stream handshake bundle between the UART ALU packet controller and its
// receiver/transmitter neighbours; the slave modport is the controller side.
interface uart_alu_ctrl_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       err_o;

    modport slave (
        input  rx_data_i, rx_valid_i, tx_ready_i,
        output rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
    );

    modport master (
        output rx_data_i, rx_valid_i, tx_ready_i,
        input  rx_ready_o, tx_data_o, tx_valid_o, busy_o, err_o
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// UART ALU packet controller: parses opcode/len headers, echoes payloads or folds
// 32-bit operands into an accumulator and streams the result. Multiply support is
// compiled in only when UART_ALU_MUL_EN is defined.
module uart_alu_ctrl #(
    parameter logic [7:0] ECHO_OPC = 8'hEC,
    parameter logic [7:0] ADD_OPC  = 8'hAD
`ifdef UART_ALU_MUL_EN
   ,parameter logic [7:0] MUL_OPC  = 8'h88
`endif
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    uart_alu_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_ECHO,
        ST_OPERAND, ST_DROP, ST_MUL_ITER, ST_SEND
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  opc_r, len_lo_r;
    logic [15:0] rem_r, len_s;
    logic [1:0]  bidx_r;
    logic [31:0] acc_r;
    logic        err_r, err_s, rdy_en_r;
    logic        rx_ready_s, tx_valid_s, rx_hs_s, tx_hs_s, last_s;
    logic [7:0]  tx_data_s;
    logic        mul_opc_s, mul_mode_s;

`ifdef UART_ALU_MUL_EN
    logic [31:0] op_r, mcand_r, prod_r, prod_step_s;
    logic [4:0]  iter_r;
    logic        mul_r;
    assign mul_opc_s   = (opc_r == MUL_OPC);
    assign mul_mode_s  = mul_r;
    assign prod_step_s = prod_r + (op_r[0] ? mcand_r : 32'd0);
`else
    logic [23:0] op_r;
    assign mul_opc_s  = 1'b0;
    assign mul_mode_s = 1'b0;
`endif

    assign len_s   = {bus.rx_data_i, len_lo_r};
    assign last_s  = (rem_r == 16'd1);
    assign rx_hs_s = bus.rx_valid_i & rx_ready_s;
    assign tx_hs_s = tx_valid_s & bus.tx_ready_i;

    // Handshake and output-data steering; ECHO is a direct rx->tx pass-through
    always_comb begin
        rx_ready_s = 1'b0;
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        case (state_r)
            ST_IDLE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_OPERAND, ST_DROP: begin
                rx_ready_s = rdy_en_r;
            end
            ST_ECHO: begin
                rx_ready_s = bus.tx_ready_i;
                tx_valid_s = bus.rx_valid_i;
                tx_data_s  = bus.rx_data_i;
            end
            ST_SEND: begin
                tx_valid_s = 1'b1;
                case (bidx_r)
                    2'd0:    tx_data_s = acc_r[7:0];
                    2'd1:    tx_data_s = acc_r[15:8];
                    2'd2:    tx_data_s = acc_r[23:16];
                    default: tx_data_s = acc_r[31:24];
                endcase
            end
            default: begin
                rx_ready_s = 1'b0;
            end
        endcase
    end

    // Next-state decode and malformed-packet detection
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE:   if (rx_hs_s) state_s = ST_RSVD;   else state_s = ST_IDLE;
            ST_RSVD:   if (rx_hs_s) state_s = ST_LEN_LO; else state_s = ST_RSVD;
            ST_LEN_LO: if (rx_hs_s) state_s = ST_LEN_HI; else state_s = ST_LEN_LO;
            ST_LEN_HI: begin
                if (!rx_hs_s) begin
                    state_s = ST_LEN_HI;
                end else if (len_s < 16'd4) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (opc_r == ECHO_OPC) begin
                    if (len_s == 16'd4) state_s = ST_IDLE; else state_s = ST_ECHO;
                end else if ((opc_r == ADD_OPC) || mul_opc_s) begin
                    if (len_s == 16'd4) state_s = ST_SEND; else state_s = ST_OPERAND;
                end else if (len_s == 16'd4) begin
                    // unknown opcode with nothing to drop
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_ECHO: if (rx_hs_s && last_s) state_s = ST_IDLE; else state_s = ST_ECHO;
            ST_OPERAND: begin
                if (!rx_hs_s) begin
                    state_s = ST_OPERAND;
                end else if (last_s && (bidx_r != 2'd3)) begin
                    err_s   = 1'b1;
                    state_s = ST_SEND;
                end else if ((bidx_r == 2'd3) && mul_mode_s) begin
                    state_s = ST_MUL_ITER;
                end else if (last_s) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_OPERAND;
                end
            end
            ST_DROP: begin
                if (rx_hs_s && last_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
`ifdef UART_ALU_MUL_EN
            ST_MUL_ITER: begin
                if (iter_r == 5'd31) begin
                    if (rem_r == 16'd0) state_s = ST_SEND; else state_s = ST_OPERAND;
                end else begin
                    state_s = ST_MUL_ITER;
                end
            end
`endif
            ST_SEND: if (tx_hs_s && (bidx_r == 2'd3)) state_s = ST_IDLE; else state_s = ST_SEND;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, header capture, operand assembly and accumulator datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            opc_r    <= 8'h00;
            len_lo_r <= 8'h00;
            rem_r    <= 16'd0;
            bidx_r   <= 2'd0;
            acc_r    <= 32'd0;
            op_r     <= '0;
            err_r    <= 1'b0;
            rdy_en_r <= 1'b0;
`ifdef UART_ALU_MUL_EN
            mcand_r  <= 32'd0;
            prod_r   <= 32'd0;
            iter_r   <= 5'd0;
            mul_r    <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            err_r    <= err_s;
            rdy_en_r <= 1'b1;
            case (state_r)
                ST_IDLE:   if (rx_hs_s) opc_r <= bus.rx_data_i;
                ST_LEN_LO: if (rx_hs_s) len_lo_r <= bus.rx_data_i;
                ST_LEN_HI: begin
                    if (rx_hs_s) begin
                        rem_r  <= len_s - 16'd4;
                        bidx_r <= 2'd0;
                        acc_r  <= mul_opc_s ? 32'd1 : 32'd0;
`ifdef UART_ALU_MUL_EN
                        mul_r  <= mul_opc_s;
`endif
                    end
                end
                ST_ECHO, ST_DROP: if (rx_hs_s) rem_r <= rem_r - 16'd1;
                ST_OPERAND: begin
                    if (rx_hs_s) begin
                        rem_r  <= rem_r - 16'd1;
                        bidx_r <= last_s ? 2'd0 : bidx_r + 2'd1;
                        case (bidx_r)
                            2'd0: op_r[7:0]   <= bus.rx_data_i;
                            2'd1: op_r[15:8]  <= bus.rx_data_i;
                            2'd2: op_r[23:16] <= bus.rx_data_i;
                            default: begin
`ifdef UART_ALU_MUL_EN
                                if (mul_r) begin
                                    op_r    <= {bus.rx_data_i, op_r[23:0]};
                                    mcand_r <= acc_r;
                                    prod_r  <= 32'd0;
                                    iter_r  <= 5'd0;
                                end else begin
                                    acc_r <= acc_r + {bus.rx_data_i, op_r[23:0]};
                                end
`else
                                acc_r <= acc_r + {bus.rx_data_i, op_r[23:0]};
`endif
                            end
                        endcase
                    end
                end
`ifdef UART_ALU_MUL_EN
                ST_MUL_ITER: begin
                    // one multiplier bit per cycle: add shifted multiplicand when set
                    prod_r  <= prod_step_s;
                    mcand_r <= {mcand_r[30:0], 1'b0};
                    op_r    <= {1'b0, op_r[31:1]};
                    iter_r  <= iter_r + 5'd1;
                    if (iter_r == 5'd31) acc_r <= prod_step_s;
                end
`endif
                ST_SEND: if (tx_hs_s) bidx_r <= bidx_r + 2'd1;
                default: begin
                end
            endcase
        end
    end

    assign bus.rx_ready_o = rx_ready_s;
    assign bus.tx_valid_o = tx_valid_s;
    assign bus.tx_data_o  = tx_data_s;
    assign bus.busy_o     = (state_r != ST_IDLE);
    assign bus.err_o      = err_r;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: table of packets with expected TX bytes
// and error-pulse counts, plus backpressure, reset and random-add sequences.
module tb_uart_alu_ctrl;
    logic clk = 1'b0;
    logic rst_ni;
    uart_alu_ctrl_if bus ();

    uart_alu_ctrl dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pkt;
        int           n;
        logic [31:0]  rsp;
        int           nrsp;
        int           nerr;
    } vec_t;

    vec_t       vecs [11];
    logic [7:0] pkt_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] tx_q  [$];
    int         err_cnt;
    int         checks;
    int         fails;

    // Passive monitor: a transfer happens on the next rising edge
    always @(negedge clk) begin
        if (rst_ni) begin
            if (bus.tx_valid_o && bus.tx_ready_i) tx_q.push_back(bus.tx_data_o);
            if (bus.err_o) err_cnt++;
        end
    end

    function automatic vec_t mk(logic [127:0] p, int n, logic [31:0] r, int nr, int ne);
        vec_t v;
        v.pkt = p; v.n = n; v.rsp = r; v.nrsp = nr; v.nerr = ne;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.rx_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got no rx_ready expected rx_ready within 200 cycles");
        end
    endtask

    task automatic wait_check(input string tag, input int exp_err);
        bit done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!bus.busy_o) begin done = 1'b1; break; end
        end
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'(done), 32'd1);
        check({tag, "_count"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            check({tag, "_byte"}, 32'(tx_q[i]), 32'(exp_q[i]));
        check({tag, "_err"}, err_cnt, exp_err);
    endtask

    task automatic run_vec(input int k);
        vec_t v = vecs[k];
        tx_q.delete(); exp_q.delete(); err_cnt = 0;
        for (int i = 0; i < v.n; i++) send_byte(v.pkt[8*(v.n-1-i) +: 8]);
        for (int i = 0; i < v.nrsp; i++) exp_q.push_back(v.rsp[8*(v.nrsp-1-i) +: 8]);
        wait_check($sformatf("vec%0d", k), v.nerr);
    endtask

    initial begin
        bit          stable;
        int          low;
        logic [31:0] sum, op;
        int          nops;

        checks = 0; fails = 0; err_cnt = 0;
        vecs[0]  = mk(128'hEC000800_42694269,          8,  32'h42694269, 4, 0);
        vecs[1]  = mk(128'hAD000C00_FFFFFFFF_02000000, 12, 32'h01000000, 4, 0);
        vecs[2]  = mk(128'hAD000300,                   4,  32'h00000000, 0, 1);
        vecs[3]  = mk(128'h5A000600_1122,              6,  32'h00000000, 0, 1);
        vecs[4]  = mk(128'hAD000900_78563412_99,       9,  32'h78563412, 4, 1);
        vecs[5]  = mk(128'hAD000400,                   4,  32'h00000000, 4, 0);
        vecs[6]  = mk(128'hEC000400,                   4,  32'h00000000, 0, 0);
        vecs[7]  = mk(128'hAD000C00_01020304_10203040, 12, 32'h11223344, 4, 0);
`ifdef UART_ALU_MUL_EN
        vecs[8]  = mk(128'h88000C00_03000000_05000000, 12, 32'h0F000000, 4, 0);
`else
        vecs[8]  = mk(128'h88000C00_03000000_05000000, 12, 32'h00000000, 0, 1);
`endif
        vecs[9]  = mk(128'hEC7E0500_A5,                5,  32'h000000A5, 1, 0);
        vecs[10] = mk(128'hEC000000,                   4,  32'h00000000, 0, 1);

        rst_ni = 1'b0;
        bus.rx_data_i = 8'h00; bus.rx_valid_i = 1'b0; bus.tx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(bus.rx_ready_o), 32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        check("rst_tx_data",  32'(bus.tx_data_o),  32'd0);
        check("rst_busy",     32'(bus.busy_o),     32'd0);
        check("rst_err",      32'(bus.err_o),      32'd0);
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
        check("idle_rx_ready", 32'(bus.rx_ready_o), 32'd1);

        for (int k = 0; k < 11; k++) run_vec(k);

        // SEND backpressure: first byte held stable for 10 cycles, nothing lost
        tx_q.delete(); exp_q.delete(); err_cnt = 0;
        bus.tx_ready_i = 1'b0;
        pkt_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        check("add_latency_valid", 32'(bus.tx_valid_o), 32'd1);
        check("add_latency_data",  32'(bus.tx_data_o),  32'hEF);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.tx_valid_o || bus.tx_data_o != 8'hEF) stable = 1'b0;
        end
        check("send_hold_stable", 32'(stable), 32'd1);
        @(posedge clk); #1;
        bus.tx_ready_i = 1'b1;
        exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wait_check("send_bp", 0);

        // ECHO backpressure: rx_ready follows tx_ready, data passes through
        tx_q.delete(); exp_q.delete(); err_cnt = 0;
        bus.tx_ready_i = 1'b0;
        pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00};
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        bus.rx_data_i = 8'h33; bus.rx_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        check("echo_bp_rx_ready", 32'(bus.rx_ready_o), 32'd0);
        check("echo_bp_tx_valid", 32'(bus.tx_valid_o), 32'd1);
        check("echo_bp_tx_data",  32'(bus.tx_data_o),  32'h33);
        @(posedge clk); #1;
        bus.tx_ready_i = 1'b1;
        send_byte(8'h33);
        exp_q = '{8'h33};
        wait_check("echo_bp", 0);

`ifdef UART_ALU_MUL_EN
        // Multiply stall: rx_ready low for exactly 32 cycles after an operand
        tx_q.delete(); exp_q.delete(); err_cnt = 0;
        pkt_q = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        low = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rx_ready_o) break;
            low++;
        end
        check("mul_stall_cycles", low, 32'd32);
        pkt_q = '{8'h05, 8'h00, 8'h00, 8'h00};
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        exp_q = '{8'h0F, 8'h00, 8'h00, 8'h00};
        wait_check("mul_seq", 0);
`endif

        // Reset after the 6th byte of an add packet, then a clean echo
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_busy_pre", 32'(bus.busy_o),     32'd0);
        check("midrst_rx_ready", 32'(bus.rx_ready_o), 32'd0);
        check("midrst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        check("midrst_tx_data",  32'(bus.tx_data_o),  32'd0);
        check("midrst_err",      32'(bus.err_o),      32'd0);
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
        run_vec(0);

        // Random add packets against a wrap-around sum model
        for (int r = 0; r < 20; r++) begin
            tx_q.delete(); exp_q.delete(); pkt_q.delete(); err_cnt = 0;
            nops = $urandom_range(1, 8);
            sum  = 32'd0;
            pkt_q.push_back(8'hAD);
            pkt_q.push_back(8'($urandom));
            pkt_q.push_back(8'(4 + 4 * nops));
            pkt_q.push_back(8'h00);
            for (int j = 0; j < nops; j++) begin
                op  = $urandom;
                sum = sum + op;
                for (int b = 0; b < 4; b++) pkt_q.push_back(op[8*b +: 8]);
            end
            for (int b = 0; b < 4; b++) exp_q.push_back(sum[8*b +: 8]);
            foreach (pkt_q[i]) send_byte(pkt_q[i]);
            wait_check($sformatf("rand%0d", r), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
